// File: rtl/decryption_pkg.sv
// Shared definitions for the decryption subsystem: engine IDs, the default
// start-decryption token and the dispatcher state encoding.
package decryption_pkg;

    localparam logic [1:0] ENG_CAESAR  = 2'd0;
    localparam logic [1:0] ENG_SCYTALE = 2'd1;
    localparam logic [1:0] ENG_ZIGZAG  = 2'd2;
    localparam int         NUM_ENG     = 3;

    localparam logic [7:0] DEFAULT_START_TOKEN = 8'hFA;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_START,
        DRAIN
    } state_t;

    // Select 3 is not an engine, so it maps to an all-zero mask.
    function automatic logic [2:0] eng_onehot(input logic [1:0] sel);
        case (sel)
            ENG_CAESAR:  eng_onehot = 3'b001;
            ENG_SCYTALE: eng_onehot = 3'b010;
            ENG_ZIGZAG:  eng_onehot = 3'b100;
            default:     eng_onehot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/decryption_out_mux.sv
// Registered 3:1 select of the engine output streams. Clear wins over enable;
// with enable low the registers hold.
module decryption_out_mux
    import decryption_pkg::*;
#(
    parameter int D_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_en,
    input  logic                   i_clr,
    input  logic [1:0]             i_sel,
    input  logic [3*D_WIDTH-1:0]   i_data,
    input  logic [2:0]             i_valid,
    output logic [D_WIDTH-1:0]     o_data,
    output logic                   o_valid
);

    logic [D_WIDTH-1:0] w_data;
    logic               w_valid;
    logic [D_WIDTH-1:0] r_data;
    logic               r_valid;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_data  = '0;
        w_valid = 1'b0;
        for (int k = 0; k < NUM_ENG; k++) begin
            if (i_sel == 2'(k)) begin
                w_data  = i_data[k*D_WIDTH +: D_WIDTH];
                w_valid = i_valid[k];
            end
        end
    end

    // NOTE: sequential state uses non-blocking <= so all registers sample pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_data  <= w_data;
            r_valid <= w_valid;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/decryption_dispatcher.sv
// Front-end scheduler: forwards a message to the engine picked at message start,
// holds off input while that engine decrypts, then returns its output stream.
module decryption_dispatcher
    import decryption_pkg::*;
#(
    parameter int                 D_WIDTH                = 8,
    parameter int                 MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = D_WIDTH'(DEFAULT_START_TOKEN),
    parameter int                 START_TIMEOUT          = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [1:0]           sel_i,
    output logic [D_WIDTH-1:0]   eng_data_o,
    output logic [2:0]           eng_valid_o,
    input  logic [2:0]           eng_busy_i,
    input  logic [3*D_WIDTH-1:0] eng_data_i,
    input  logic [2:0]           eng_valid_i,
    output logic                 busy_o,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o,
    output logic                 err_o
);

    localparam int               CNT_W    = $clog2(MAX_NOF_CHARS + 1);
    localparam int               TMR_W    = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_NOF_CHARS);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(START_TIMEOUT - 1);

    state_t             r_state, w_state_next;
    logic [1:0]         r_sel_q, w_sel_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [TMR_W-1:0]   r_timer, w_timer_next;
    logic               r_ovf_seen, w_ovf_next;
    logic               r_busy, w_busy_next;
    logic               r_err, w_err_next;
    logic [D_WIDTH-1:0] r_eng_data;
    logic [2:0]         r_eng_valid;
    logic               w_fwd;
    logic [2:0]         w_fwd_onehot;
    logic               w_mux_en, w_mux_clr;

    logic w_char, w_token, w_sel_busy, w_timeout;
    assign w_char     = valid_i && (data_i != '0) && (data_i != START_DECRYPTION_TOKEN);
    assign w_token    = valid_i && (data_i == START_DECRYPTION_TOKEN);
    assign w_sel_busy = |(eng_busy_i & eng_onehot(r_sel_q));
    assign w_timeout  = (r_timer == TMR_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:       if (w_char && sel_i != 2'd3) w_state_next = LOAD;
            LOAD:       if (w_token)                 w_state_next = WAIT_START;
            WAIT_START: if (w_sel_busy)              w_state_next = DRAIN;
                        else if (w_timeout)          w_state_next = IDLE;
            DRAIN:      if (!w_sel_busy)             w_state_next = IDLE;
            default:                                 w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_sel_next   = r_sel_q;
        w_cnt_next   = r_cnt;
        w_timer_next = r_timer;
        w_ovf_next   = r_ovf_seen;
        w_busy_next  = r_busy;
        w_err_next   = 1'b0;
        w_fwd        = 1'b0;
        w_fwd_onehot = eng_onehot(r_sel_q);
        w_mux_en     = 1'b0;
        w_mux_clr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_char) begin
                    w_sel_next = sel_i;
                    if (sel_i == 2'd3) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_fwd        = 1'b1;
                        w_fwd_onehot = eng_onehot(sel_i);
                        w_cnt_next   = CNT_W'(1);
                        w_ovf_next   = 1'b0;
                    end
                end
            end
            LOAD: begin
                if (w_char) begin
                    if (r_cnt < CNT_MAX) begin
                        w_fwd      = 1'b1;
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end else if (!r_ovf_seen) begin
                        // Overflow is reported only on the first dropped char of a message.
                        w_err_next = 1'b1;
                        w_ovf_next = 1'b1;
                    end
                end else if (w_token) begin
                    w_fwd        = 1'b1;
                    w_busy_next  = 1'b1;
                    w_timer_next = '0;
                end
            end
            WAIT_START: begin
                if (!w_sel_busy) begin
                    if (w_timeout) begin
                        w_err_next  = 1'b1;
                        w_busy_next = 1'b0;
                        w_cnt_next  = '0;
                    end else begin
                        w_timer_next = r_timer + TMR_W'(1);
                    end
                end
            end
            DRAIN: begin
                w_mux_en = 1'b1;
                if (!w_sel_busy) begin
                    w_mux_clr   = 1'b1;
                    w_busy_next = 1'b0;
                    w_cnt_next  = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel_q     <= '0;
            r_cnt       <= '0;
            r_timer     <= '0;
            r_ovf_seen  <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_eng_data  <= '0;
            r_eng_valid <= '0;
        end else begin
            r_sel_q     <= w_sel_next;
            r_cnt       <= w_cnt_next;
            r_timer     <= w_timer_next;
            r_ovf_seen  <= w_ovf_next;
            r_busy      <= w_busy_next;
            r_err       <= w_err_next;
            r_eng_valid <= w_fwd ? w_fwd_onehot : 3'b000;
            if (w_fwd) r_eng_data <= data_i;
        end
    end

    decryption_out_mux #(.D_WIDTH(D_WIDTH)) u_out_mux (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_mux_en),
        .i_clr   (w_mux_clr),
        .i_sel   (r_sel_q),
        .i_data  (eng_data_i),
        .i_valid (eng_valid_i),
        .o_data  (data_o),
        .o_valid (valid_o)
    );

    assign eng_data_o  = r_eng_data;
    assign eng_valid_o = r_eng_valid;
    assign busy_o      = r_busy;
    assign err_o       = r_err;

endmodule
